// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch-stage sequencer: state encodings,
// stall-vector constants, chip-enable levels and the address width.
package pc_ctrl_pkg;

   // Instruction address bus width
   localparam int INST_ADDR_W = 32;

   // Reset and chip-enable levels
   localparam logic RST_ENA   = 1'b1;
   localparam logic CHIP_ENA  = 1'b1;
   localparam logic CHIP_DISA = 1'b0;

   // Default exception vector
   localparam logic [INST_ADDR_W-1:0] EXC_VECTOR_DEF = 32'h0000_0020;

   // Stall vectors: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_IMEM = 6'b000011;

   // Sequencer states
   typedef enum logic [1:0] {
      S_OFF  = 2'd0,
      S_BOOT = 2'd1,
      S_RUN  = 2'd2,
      S_WAIT = 2'd3
   } state_t;

   // Redirect targets are always word aligned; the low bits are dropped
   // rather than trapped.
   function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
      return {addr[INST_ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_ctrl_stall_merge.sv
// Combinational priority encoder turning the stage requests into the
// per-stage stall vector seen by the pipeline registers.
module pc_ctrl_stall_merge
   import pc_ctrl_pkg::*;
(
   input  logic       i_run,
   input  logic       i_wait,
   input  logic       i_flush,
   input  logic       i_stallreq_ex,
   input  logic       i_branch,
   input  logic       i_stallreq_id,
   input  logic       i_imem_ready,
   output logic [5:0] o_stall
);

   // Fixed priority: flush, EX busy, branch, load-use, memory wait.
   // A branch beats a load-use stall because the redirect squashes the
   // instruction that asked for it.
   always_comb begin
      o_stall = STALL_NONE;
      if (i_run) begin
         if (i_flush)
            o_stall = STALL_NONE;
         else if (i_stallreq_ex)
            o_stall = STALL_EX;
         else if (i_branch)
            o_stall = STALL_NONE;
         else if (i_stallreq_id)
            o_stall = STALL_ID;
         else if (!i_imem_ready)
            o_stall = STALL_IMEM;
      end else if (i_wait) begin
         if (!i_flush && !i_imem_ready)
            o_stall = STALL_IMEM;
      end
   end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage sequencer: owns the PC and instruction-memory chip enable,
// picks the next fetch address and publishes stall / flush controls.
module pc_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter logic [INST_ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
   parameter logic [INST_ADDR_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stallreq_id,
   input  logic                   stallreq_ex,
   input  logic                   imem_ready,
   input  logic                   branch_flag,
   input  logic [INST_ADDR_W-1:0] branch_target,
   input  logic                   flush,
   output logic [INST_ADDR_W-1:0] pc,
   output logic                   ce,
   output logic [5:0]             stall,
   output logic                   flush_out
);

   state_t                 r_state;
   state_t                 w_state_next;
   logic [INST_ADDR_W-1:0] r_pc;
   logic [INST_ADDR_W-1:0] w_pc_next;
   logic                   r_ce;
   logic                   w_ce_next;
   logic                   r_pend_vld;
   logic                   w_pend_vld_next;
   logic [INST_ADDR_W-1:0] r_pend_tgt;
   logic [INST_ADDR_W-1:0] w_pend_tgt_next;
   logic                   w_run;
   logic                   w_wait;
   logic [INST_ADDR_W-1:0] w_pc_inc;
   logic [INST_ADDR_W-1:0] w_br_tgt;

   assign w_run    = (r_state == S_RUN);
   assign w_wait   = (r_state == S_WAIT);
   assign w_pc_inc = r_pc + 32'd4;
   assign w_br_tgt = word_align(branch_target);

   assign pc = r_pc;
   assign ce = r_ce;

   pc_ctrl_stall_merge u_stall_merge (
      .i_run         (w_run),
      .i_wait        (w_wait),
      .i_flush       (flush),
      .i_stallreq_ex (stallreq_ex),
      .i_branch      (branch_flag),
      .i_stallreq_id (stallreq_id),
      .i_imem_ready  (imem_ready),
      .o_stall       (stall)
   );

   // State, PC, chip enable and pending-redirect registers
   always_ff @(posedge clk) begin
      if (rst == RST_ENA) begin
         r_state    <= S_OFF;
         r_pc       <= RESET_PC;
         r_ce       <= CHIP_DISA;
         r_pend_vld <= 1'b0;
         r_pend_tgt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_pc       <= w_pc_next;
         r_ce       <= w_ce_next;
         r_pend_vld <= w_pend_vld_next;
         r_pend_tgt <= w_pend_tgt_next;
      end
   end

   // Next-state and next-PC selection, plus the flush strobe
   always_comb begin
      w_state_next    = r_state;
      w_pc_next       = r_pc;
      w_ce_next       = r_ce;
      w_pend_vld_next = r_pend_vld;
      w_pend_tgt_next = r_pend_tgt;
      flush_out       = 1'b0;
      case (r_state)
         S_OFF: begin
            // Leaving reset: start the first fetch at the reset address
            w_state_next    = S_BOOT;
            w_pc_next       = RESET_PC;
            w_ce_next       = CHIP_ENA;
            w_pend_vld_next = 1'b0;
         end
         S_BOOT: begin
            // First fetch occupies exactly one cycle
            w_state_next = S_RUN;
            w_pc_next    = w_pc_inc;
         end
         S_RUN: begin
            if (flush) begin
               w_pc_next = EXC_VECTOR;
               flush_out = 1'b1;
            end else if (stallreq_ex) begin
               // Hold; ID keeps the branch asserted until it is taken
               w_pc_next = r_pc;
            end else if (branch_flag) begin
               w_pc_next = w_br_tgt;
            end else if (stallreq_id) begin
               w_pc_next = r_pc;
            end else if (!imem_ready) begin
               w_state_next = S_WAIT;
            end else begin
               w_pc_next = w_pc_inc;
            end
         end
         S_WAIT: begin
            if (flush) begin
               // Outstanding fetch and any pending redirect are dropped
               w_pc_next       = EXC_VECTOR;
               flush_out       = 1'b1;
               w_state_next    = S_RUN;
               w_pend_vld_next = 1'b0;
            end else if (imem_ready) begin
               // A branch arriving with the data is the newest redirect
               if (branch_flag)
                  w_pc_next = w_br_tgt;
               else if (r_pend_vld)
                  w_pc_next = r_pend_tgt;
               else
                  w_pc_next = w_pc_inc;
               w_state_next    = S_RUN;
               w_pend_vld_next = 1'b0;
            end else if (branch_flag) begin
               w_pend_vld_next = 1'b1;
               w_pend_tgt_next = w_br_tgt;
            end
         end
         default: begin
            w_state_next = S_OFF;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pc_ctrl;

   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        imem_ready;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        flush;
   logic [31:0] pc;
   logic        ce;
   logic [5:0]  stall;
   logic        flush_out;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: what the fetch unit must be doing, as plain facts
   bit          m_init = 1'b0;  // model has seen a reset
   bit          m_live = 1'b0;  // out of reset
   bit          m_boot = 1'b0;  // first fetch in progress
   bit          m_wait = 1'b0;  // waiting on instruction memory
   bit          m_ce   = 1'b0;
   logic [31:0] m_pc   = '0;
   bit          m_pend = 1'b0;  // redirect remembered while waiting
   logic [31:0] m_pend_addr = '0;

   always #5 clk = ~clk;

   pc_ctrl #(
      .RESET_PC   (RESET_PC),
      .EXC_VECTOR (EXC_VECTOR)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stallreq_id   (stallreq_id),
      .stallreq_ex   (stallreq_ex),
      .imem_ready    (imem_ready),
      .branch_flag   (branch_flag),
      .branch_target (branch_target),
      .flush         (flush),
      .pc            (pc),
      .ce            (ce),
      .stall         (stall),
      .flush_out     (flush_out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Pipeline is fetching normally (not in reset, not on the boot fetch)
   function automatic bit m_fetching();
      return m_live && !m_boot;
   endfunction

   function automatic logic [5:0] exp_stall();
      if (!m_fetching() || flush) return 6'b000000;
      if (m_wait) return imem_ready ? 6'b000000 : 6'b000011;
      if (stallreq_ex) return 6'b001111;
      if (branch_flag) return 6'b000000;
      if (stallreq_id) return 6'b000111;
      if (!imem_ready) return 6'b000011;
      return 6'b000000;
   endfunction

   // Advance the model on every rising edge
   always @(posedge clk) begin
      automatic logic [31:0] tgt = branch_target & ~32'h3;
      if (rst) begin
         m_init <= 1'b1;
         m_live <= 1'b0;
         m_boot <= 1'b0;
         m_wait <= 1'b0;
         m_pend <= 1'b0;
         m_ce   <= 1'b0;
         m_pc   <= RESET_PC;
      end else if (!m_live) begin
         m_live <= 1'b1;
         m_boot <= 1'b1;
         m_ce   <= 1'b1;
         m_pc   <= RESET_PC;
      end else if (m_boot) begin
         m_boot <= 1'b0;
         m_pc   <= m_pc + 32'd4;
      end else if (m_wait) begin
         if (flush) begin
            m_pc   <= EXC_VECTOR;
            m_wait <= 1'b0;
            m_pend <= 1'b0;
         end else if (imem_ready) begin
            m_pc   <= branch_flag ? tgt : (m_pend ? m_pend_addr : m_pc + 32'd4);
            m_wait <= 1'b0;
            m_pend <= 1'b0;
         end else if (branch_flag) begin
            m_pend      <= 1'b1;
            m_pend_addr <= tgt;
         end
      end else begin
         if (flush)            m_pc   <= EXC_VECTOR;
         else if (stallreq_ex) m_pc   <= m_pc;
         else if (branch_flag) m_pc   <= tgt;
         else if (stallreq_id) m_pc   <= m_pc;
         else if (!imem_ready) m_wait <= 1'b1;
         else                  m_pc   <= m_pc + 32'd4;
      end
   end

   // Compare DUT against the model away from the active edge
   always @(negedge clk) begin
      if (m_init) begin
         chk("pc", pc, m_pc);
         chk("ce", {31'b0, ce}, {31'b0, m_ce});
         chk("stall", {26'b0, stall}, {26'b0, exp_stall()});
         chk("flush_out", {31'b0, flush_out}, {31'b0, m_fetching() && flush});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      stallreq_id = 1'b0;
      stallreq_ex = 1'b0;
      branch_flag = 1'b0;
      flush       = 1'b0;
      imem_ready  = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      branch_target = '0;
      clear_req();

      // Reset release: ce low in reset, then pc 0,0,4,8,C
      repeat (3) tick();
      chk("rst_ce", {31'b0, ce}, 32'h0);
      chk("rst_pc", pc, 32'h0);
      rst = 1'b0;
      tick(); chk("boot_ce", {31'b0, ce}, 32'h1); chk("boot_pc", pc, 32'h0);
      tick(); chk("seq_pc4", pc, 32'h4);
      tick(); chk("seq_pc8", pc, 32'h8);
      tick(); chk("seq_pcC", pc, 32'hC);
      tick(); chk("seq_pc10", pc, 32'h10);

      // Branch with misaligned target
      branch_flag = 1'b1; branch_target = 32'h43;
      tick(); chk("br_pc", pc, 32'h40);
      branch_flag = 1'b0;
      tick(); chk("br_inc", pc, 32'h44);

      // EX stall beats branch, then branch taken alone
      branch_flag = 1'b1; branch_target = 32'h20;
      tick(); chk("br_to20", pc, 32'h20);
      stallreq_ex = 1'b1; branch_target = 32'h80;
      #1 chk("ex_stall", {26'b0, stall}, 32'h0F);
      tick(); chk("ex_hold1", pc, 32'h20);
      tick(); chk("ex_hold2", pc, 32'h20);
      stallreq_ex = 1'b0;
      tick(); chk("ex_redir", pc, 32'h80);
      branch_flag = 1'b0;

      // Load-use stall, then branch beating load-use
      stallreq_id = 1'b1;
      #1 chk("id_stall", {26'b0, stall}, 32'h07);
      tick(); chk("id_hold", pc, 32'h80);
      stallreq_id = 1'b0;
      tick(); chk("id_resume", pc, 32'h84);
      stallreq_id = 1'b1; branch_flag = 1'b1; branch_target = 32'h8;
      #1 chk("br_id_stall", {26'b0, stall}, 32'h0);
      tick(); chk("br_id_pc", pc, 32'h8);
      clear_req();

      // Memory wait with a redirect pulsed during the wait
      imem_ready = 1'b0;
      #1 chk("imem_stall", {26'b0, stall}, 32'h03);
      tick(); chk("wait_hold1", pc, 32'h8);
      branch_flag = 1'b1; branch_target = 32'h100;
      tick(); chk("wait_hold2", pc, 32'h8);
      branch_flag = 1'b0;
      tick(); chk("wait_hold3", pc, 32'h8);
      #1 chk("wait_stall", {26'b0, stall}, 32'h03);
      imem_ready = 1'b1;
      tick(); chk("wait_redir", pc, 32'h100);
      tick(); chk("wait_inc", pc, 32'h104);

      // Flush overrides branch and load-use
      flush = 1'b1; branch_flag = 1'b1; stallreq_id = 1'b1; branch_target = 32'h300;
      #1 chk("flush_out", {31'b0, flush_out}, 32'h1);
      chk("flush_stall", {26'b0, stall}, 32'h0);
      tick(); chk("flush_pc", pc, EXC_VECTOR);
      clear_req();
      tick(); chk("flush_inc", pc, 32'h24);

      // Wrap at the top of the address space
      branch_flag = 1'b1; branch_target = 32'hFFFF_FFFF;
      tick(); chk("wrap_top", pc, 32'hFFFF_FFFC);
      branch_flag = 1'b0;
      tick(); chk("wrap_zero", pc, 32'h0);
      tick(); chk("wrap_inc", pc, 32'h4);

      // Reset while waiting with a redirect pending
      imem_ready = 1'b0;
      tick(); chk("mr_hold", pc, 32'h4);
      branch_flag = 1'b1; branch_target = 32'h200;
      tick(); chk("mr_pend", pc, 32'h4);
      branch_flag = 1'b0; rst = 1'b1;
      tick(); chk("mr_ce", {31'b0, ce}, 32'h0); chk("mr_pc", pc, 32'h0);
      rst = 1'b0; imem_ready = 1'b1;
      tick(); chk("mr_boot_ce", {31'b0, ce}, 32'h1); chk("mr_boot_pc", pc, 32'h0);
      tick(); chk("mr_seq4", pc, 32'h4);
      tick(); chk("mr_seq8", pc, 32'h8);

      // Randomized traffic, checked every cycle against the model
      repeat (2000) begin
         rst         = ($urandom_range(0, 99) == 0);
         flush       = ($urandom_range(0, 15) == 0);
         stallreq_ex = ($urandom_range(0, 5) == 0);
         stallreq_id = ($urandom_range(0, 5) == 0);
         branch_flag = ($urandom_range(0, 4) == 0);
         imem_ready  = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0)
            branch_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else
            branch_target = $urandom();
         tick();
      end

      clear_req();
      rst = 1'b0;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Fetch-stage sequencer for the five-stage MIPS pipeline. It owns the program counter and instruction-memory chip enable, and chooses the next PC each cycle: sequential increment, branch redirect, exception vector, or hold. It also merges the stage stall requests into the per-stage stall vector consumed by the pipeline registers. It sits in front of the instruction ROM, between the ID/EX stages (redirect and stall sources) and the IF/ID register.

## Interface
Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- EXC_VECTOR, 32'h00000020, fetch address taken on flush.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset (`RstEna`).
- stallreq_id  input  1  ID stage needs an extra cycle (load-use).
- stallreq_ex  input  1  EX stage multi-cycle op busy.
- imem_ready  input  1  instruction memory returns data this cycle; low = wait.
- branch_flag  input  1  ID resolved a taken branch or jump.
- branch_target  input  32  redirect address from ID.
- flush  input  1  exception/flush from MEM.
- pc  output  32 (`InstAddrBus`)  fetch address to instruction memory.
- ce  output  1  instruction memory chip enable (`ChipEna`/`ChipDisa`).
- stall  output  6  stall vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (0).
- flush_out  output  1  clear IF/ID and ID/EX registers this cycle.

## Operation
- FSM states: S_OFF, S_BOOT, S_RUN, S_WAIT.
- S_OFF (reset): ce=0, pc=RESET_PC, stall=0, flush_out=0. When rst=0, go to S_BOOT.
- S_BOOT: ce=1, pc held at RESET_PC for exactly one cycle (first fetch), then go to S_RUN.
- S_RUN: next PC chosen by fixed priority:
  1. flush: pc<=EXC_VECTOR, flush_out=1.
  2. stallreq_ex: hold pc, stall=6'b001111, branch_flag ignored (ID re-presents it).
  3. branch_flag: pc<=branch_target with bits [1:0] forced to 0.
  4. stallreq_id: hold pc, stall=6'b000111.
  5. !imem_ready: hold pc, stall=6'b000011, go to S_WAIT.
  6. Otherwise: pc<=pc+4.
- S_WAIT: hold pc, stall=6'b000011 until imem_ready=1, then pc<=pc+4 and return to S_RUN.
  - flush in S_WAIT: pc<=EXC_VECTOR, flush_out=1, return to S_RUN (outstanding fetch discarded).
  - branch_flag in S_WAIT: latched into a pending-redirect register and applied instead of +4 when imem_ready rises.
- Arithmetic: pc is 32-bit and wraps mod 2^32 (32'hFFFFFFFC+4 -> 0). No misalignment trap; low bits are masked.
- stall and flush_out are combinational from the current state and inputs. pc, ce and state are registered.

## Timing
- rst is sampled on posedge only. Asserting it mid-operation forces S_OFF on the next edge (ce=0, pc=RESET_PC) and discards any pending redirect.
- Edge after rst deasserts: ce=1, pc=RESET_PC. One edge later: pc=RESET_PC+4 (absent stalls).
- Redirect latency: branch_flag high at edge N gives pc=branch_target after edge N. Flush is the same, one cycle.
- A stall holds pc for exactly as many cycles as the request is high. Increment resumes on the first edge with the request low.
- Simultaneous flush and any other input: flush wins. Simultaneous stallreq_ex and branch: stall wins, no redirect.

## Structure
- Add to define.v: the state encodings, the stall-vector constants (STALL_NONE, STALL_ID, STALL_EX, STALL_IMEM), and the EXC_VECTOR default. Use the existing `RstEna`, `ChipEna`/`ChipDisa` and `InstAddrBus`.
- One natural sub-module: stall_merge, the combinational priority encoder from requests to the stall vector. The next-PC mux and FSM stay in pc_ctrl.

## Test plan
- Reset release: rst=1 for 3 cycles, then 0 -> ce 0 during reset; pc sequence 0,0,4,8,C on successive edges.
- Branch: at pc=0x10 drive branch_flag=1, branch_target=0x43 -> next pc=0x40, then 0x44.
- Stall priority: stallreq_ex=1 and branch_flag=1 for 2 cycles at pc=0x20 -> pc held at 0x20, stall=6'b001111. Branch re-presented alone -> redirect taken.
- Memory wait: imem_ready=0 for 3 cycles at pc=0x8 with branch_flag pulsed (target 0x100) -> pc held, stall=6'b000011, then pc=0x100.
- Flush override: flush, branch_flag and stallreq_id all high -> pc=EXC_VECTOR, flush_out=1. Wrap check: pc=0xFFFFFFFC -> 0x0.
- Mid-run reset: rst=1 for one cycle while in S_WAIT with a redirect pending -> ce=0, pc=0, pending redirect lost, boot sequence repeats.
